// File: rtl/mult_pkg.sv
// Shared constants and FSM state encoding for the product accumulator.
package mult_pkg;

    localparam int PROD_W_DEF = 16;
    localparam int ACC_W_DEF  = 20;
    localparam int LEN_W_DEF  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/sat_adder.sv
// Unsigned W-bit adder that clamps to all-ones on carry-out and flags the overflow.
module sat_adder #(
    parameter int W = 20
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         ovf
);

    logic [W:0] raw;

    assign raw = {1'b0, a} + {1'b0, b};
    assign ovf = raw[W];
    assign sum = raw[W] ? {W{1'b1}} : raw[W-1:0];

endmodule

// File: rtl/product_accumulator.sv
// Accumulates a block of len unsigned products with saturation and presents
// the block sum on a valid/ready output held until consumed.
module product_accumulator
    import mult_pkg::*;
#(
    parameter int PROD_W = PROD_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_product,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic              out_sat,
    output logic              busy
);

    state_t             state;
    state_t             state_next;
    logic [ACC_W-1:0]   acc;
    logic [LEN_W-1:0]   remaining;
    logic               sat;
    logic [ACC_W-1:0]   add_sum;
    logic               add_ovf;
    logic               accept;

    assign accept = (state == ACCUM) && in_valid;

    sat_adder #(.W(ACC_W)) u_sat_adder (
        .a   (acc),
        .b   (ACC_W'(in_product)),
        .sum (add_sum),
        .ovf (add_ovf)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: default assignment first so no path leaves state_next unassigned
    // (which would infer a latch).
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = (len == '0) ? HOLD : ACCUM;
            ACCUM:   if (in_valid && remaining == LEN_W'(1)) state_next = HOLD;
            HOLD:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == ACCUM);
        out_valid = (state == HOLD);
        busy      = (state != IDLE);
    end

    // Accumulator doubles as the result register: it is only cleared when a
    // new block starts, so IDLE keeps showing the last block's sum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            remaining <= '0;
            sat       <= 1'b0;
        end else if (state == IDLE && start) begin
            acc       <= '0;
            remaining <= len;
            sat       <= 1'b0;
        end else if (accept) begin
            acc       <= add_sum;
            remaining <= remaining - LEN_W'(1);
            sat       <= sat | add_ovf;
        end
    end

    assign out_sum = acc;
    assign out_sat = sat;

endmodule

// File: doc/product_accumulator.md
PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 SHALL have parameter PROD_W, 16, width of each incoming product.
REQ-002 SHALL have parameter ACC_W, 20, accumulator and result width (ACC_W >= PROD_W).
REQ-003 SHALL have parameter LEN_W, 8, width of the block-length field.
REQ-004 SHALL use one clock; reset is asynchronous and active-high.
REQ-005 SHALL have port clk  input  1  rising-edge clock.
REQ-006 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-007 SHALL have port start  input  1  one-cycle request to begin a block; sampled only in IDLE.
REQ-008 SHALL have port len  input  LEN_W  number of products in the block, captured with start.
REQ-009 SHALL have port in_valid  input  1  upstream multiplier product valid.
REQ-010 SHALL have port in_ready  output  1  accumulator can accept a product this cycle.
REQ-011 SHALL have port in_product  input  PROD_W  unsigned product from the upstream multiplier.
REQ-012 SHALL have port out_valid  output  1  block result available.
REQ-013 SHALL have port out_ready  input  1  downstream consumes result.
REQ-014 SHALL have port out_sum  output  ACC_W  saturated block sum.
REQ-015 SHALL have port out_sat  output  1  sum saturated at least once during the block.
REQ-016 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-017 SHALL implement an FSM with states IDLE, ACCUM and HOLD.
REQ-018 SHALL, in IDLE with start=1 and len>0, clear the accumulator and out_sat, load remaining=len, and enter ACCUM.
REQ-019 SHALL, in IDLE with start=1 and len=0, enter HOLD with out_sum=0 and out_sat=0.
REQ-020 SHALL drive in_ready=1 only in ACCUM (combinational from state, not from in_valid).
REQ-021 SHALL, on in_valid&in_ready, add the zero-extended in_product into the accumulator and decrement remaining, sustaining one product per cycle.
REQ-022 SHALL clamp the sum at 2^ACC_W-1 on overflow and set out_sat, which stays high until the next block starts.
REQ-023 SHALL enter HOLD on the clock edge that accepts the product with remaining=1; out_valid rises the following cycle (latency 1 after the last product).
REQ-024 SHALL hold out_valid=1 and keep out_sum and out_sat stable in HOLD until out_ready=1, then return to IDLE on that edge.
REQ-025 SHALL ignore start while busy=1, and ignore in_valid outside ACCUM (product not consumed).
REQ-026 SHALL keep out_valid=0 outside HOLD; out_sum retains the last block value in IDLE.

Reset
REQ-027 SHALL, on rst=1 at any time, including mid-block, immediately force IDLE, accumulator=0, remaining=0, out_sum=0, out_sat=0, out_valid=0, in_ready=0, busy=0.
REQ-028 SHALL discard any partial block on reset; no result is emitted for it.

Structure
REQ-029 SHALL place the FSM state enum and default PROD_W/ACC_W/LEN_W constants in shared package mult_pkg.
REQ-030 SHALL isolate the saturating add in one sub-module, sat_adder (ACC_W-bit unsigned add with clamp and overflow flag).

Verification
REQ-031 SHALL cover start with len=3 and back-to-back products 10, 20, 30 -> out_valid one cycle after the third product, out_sum=60, out_sat=0.
REQ-032 SHALL cover len=17 with every product 65535 -> out_sum=1048575, out_sat=1, in_ready low after 17 accepts.
REQ-033 SHALL cover len=0 start -> out_valid next cycle with out_sum=0; start pulses during HOLD are ignored.
REQ-034 SHALL cover out_ready held low for 5 cycles in HOLD -> out_valid, out_sum stable; in_ready=0 throughout; IDLE after out_ready=1.
REQ-035 SHALL cover rst asserted after 2 of 4 products -> all outputs zero immediately; a new len=1 block with product 7 then yields out_sum=7.
REQ-036 SHALL cover gaps in in_valid (1-cycle bubbles) with len=4 -> sum of the 4 accepted products, no extra or missed accepts.
